// File: rtl/timer_counter_gen2.sv
// Up/down timer core with prescaler or synchronised external tick, one-shot/periodic modes,
// compare match and W1C status. Optional capture unit enabled by defining TIMER_CAPTURE_EN.
module timer_counter_gen2 #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 clk_in,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 one_shot,
  input  logic                 clk_sel,
  input  logic [PSC_WIDTH-1:0] psc_div,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic [WIDTH-1:0]     reload_val,
  input  logic [WIDTH-1:0]     cmp_val,
  input  logic [3:0]           tsr_clr,
  input  logic [3:0]           irq_mask,
  input  logic                 cap_in,
  output logic [WIDTH-1:0]     tcnt,
  output logic [3:0]           tsr,
  output logic [WIDTH-1:0]     cap_val,
  output logic                 running,
  output logic                 irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PSC_WIDTH-1:0] PSC_ONE = {{(PSC_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [PSC_WIDTH-1:0]   psc_cnt_q, psc_cnt_d;
  logic [2:0]             sync_q, sync_d;
  logic [WIDTH-1:0]       tcnt_q, tcnt_d;
  logic [3:0]             tsr_q, tsr_d;
  logic                   irq_q, irq_d;
  logic                   in_run, ext_tick, int_tick, cnt_tick, wrap;
  logic [3:0]             set_flags;
  logic                   cap_evt;

  // Tick generation: sync[1]/sync[2] pair forms the rising-edge detector on clk_in.
  always_comb begin
    sync_d   = {sync_q[1:0], clk_in};
    in_run   = (state_q == RUN);
    ext_tick = sync_q[1] & ~sync_q[2];
    int_tick = in_run && (psc_cnt_q == psc_div);
    cnt_tick = in_run && !load && (clk_sel ? ext_tick : int_tick);

    psc_cnt_d = psc_cnt_q + PSC_ONE;
    if (load || !in_run || (psc_cnt_q == psc_div)) begin
      psc_cnt_d = '0;
    end
  end

  // Counter update and flag setting; load overrides and swallows the tick.
  always_comb begin
    tcnt_d    = tcnt_q;
    wrap      = 1'b0;
    set_flags = 4'b0000;
    if (load) begin
      tcnt_d = load_val;
    end else if (cnt_tick) begin
      if (!dir) begin
        if (tcnt_q == '1) begin
          tcnt_d       = reload_val;
          wrap         = 1'b1;
          set_flags[0] = 1'b1;
        end else begin
          tcnt_d = tcnt_q + CNT_ONE;
        end
      end else begin
        if (tcnt_q == '0) begin
          tcnt_d       = reload_val;
          wrap         = 1'b1;
          set_flags[1] = 1'b1;
        end else begin
          tcnt_d = tcnt_q - CNT_ONE;
        end
      end
      set_flags[2] = (tcnt_d == cmp_val);
    end
    set_flags[3] = cap_evt;

    tsr_d = set_flags | (tsr_q & ~tsr_clr);
    irq_d = |(tsr_q & irq_mask);
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      if ((state_q == HALT) && !en) begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: if (en) state_d = RUN;
        RUN: begin
          if (!en) begin
            state_d = IDLE;
          end else if (wrap && one_shot) begin
            state_d = HALT;
          end
        end
        HALT: if (!en) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      psc_cnt_q <= '0;
      sync_q    <= '0;
      tcnt_q    <= '0;
      tsr_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      psc_cnt_q <= psc_cnt_d;
      sync_q    <= sync_d;
      tcnt_q    <= tcnt_d;
      tsr_q     <= tsr_d;
      irq_q     <= irq_d;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]       cap_sync_q, cap_sync_d;
  logic [WIDTH-1:0] cap_val_q, cap_val_d;

  // Capture samples the pre-update count so a coincident load or tick is not seen.
  always_comb begin
    cap_sync_d = {cap_sync_q[1:0], cap_in};
    cap_evt    = cap_sync_q[1] & ~cap_sync_q[2];
    cap_val_d  = cap_evt ? tcnt_q : cap_val_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cap_sync_q <= '0;
      cap_val_q  <= '0;
    end else begin
      cap_sync_q <= cap_sync_d;
      cap_val_q  <= cap_val_d;
    end
  end

  assign cap_val = cap_val_q;
`else
  logic unused_cap_in;
  assign unused_cap_in = cap_in;
  assign cap_evt       = 1'b0;
  assign cap_val       = '0;
`endif

  assign tcnt    = tcnt_q;
  assign tsr     = tsr_q;
  assign running = in_run;
  assign irq     = irq_q;

endmodule

// File: tb/tb_timer_counter_gen2.sv
// Directed scoreboard bench for timer_counter_gen2 at WIDTH=8; capture expectations follow TIMER_CAPTURE_EN.
module tb_timer_counter_gen2;

  localparam int W = 8;
  localparam int P = 8;
`ifdef TIMER_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic         clk_in, en, dir, one_shot, clk_sel, load, cap_in;
  logic [P-1:0] psc_div;
  logic [W-1:0] load_val, reload_val, cmp_val;
  logic [3:0]   tsr_clr, irq_mask;
  logic [W-1:0] tcnt, cap_val;
  logic [3:0]   tsr;
  logic         running, irq;

  timer_counter_gen2 #(.WIDTH(W), .PSC_WIDTH(P)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .clk_in(clk_in), .en(en), .dir(dir),
    .one_shot(one_shot), .clk_sel(clk_sel), .psc_div(psc_div), .load(load),
    .load_val(load_val), .reload_val(reload_val), .cmp_val(cmp_val),
    .tsr_clr(tsr_clr), .irq_mask(irq_mask), .cap_in(cap_in), .tcnt(tcnt),
    .tsr(tsr), .cap_val(cap_val), .running(running), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic lat_ok;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return 32'(tcnt);
      1:       return 32'(tsr);
      2:       return 32'(cap_val);
      3:       return 32'(running);
      4:       return 32'(irq);
      default: return 32'(lat_ok);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_checks++;
      assert (obs === e.exp) else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    logic [W-1:0] prev;
    int           lat;

    PRESETn = 1'b0; clk_in = 1'b0; en = 1'b0; dir = 1'b0; one_shot = 1'b0;
    clk_sel = 1'b0; load = 1'b0; cap_in = 1'b0; psc_div = '0; load_val = '0;
    reload_val = '0; cmp_val = 8'hAA; tsr_clr = '0; irq_mask = '0;
    step(2);
    expect_val("rst_tcnt", 0, 0); expect_val("rst_tsr", 1, 0);
    expect_val("rst_cap", 2, 0); expect_val("rst_run", 3, 0); expect_val("rst_irq", 4, 0);
    check_all();
    PRESETn = 1'b1;

    // Up, periodic, prescaler /4, wrap from 0xFF to reload with ovf and irq
    psc_div = 8'd3; reload_val = 8'h10; irq_mask = 4'b0001;
    load = 1'b1; load_val = 8'hFE;
    step(1);
    load = 1'b0; en = 1'b1;
    step(1);
    expect_val("up_start", 0, 8'hFE); expect_val("up_run", 3, 1); check_all();
    step(3); expect_val("up_psc_hold", 0, 8'hFE); check_all();
    step(1); expect_val("up_ff", 0, 8'hFF); check_all();
    step(3); expect_val("up_ff_hold", 0, 8'hFF); expect_val("up_tsr0", 1, 0); check_all();
    step(1);
    expect_val("up_wrap", 0, 8'h10); expect_val("up_ovf", 1, 4'b0001);
    expect_val("up_irq_lag", 4, 0); check_all();
    step(1); expect_val("up_irq", 4, 1); expect_val("up_ovf_sticky", 1, 4'b0001); check_all();
    tsr_clr = 4'b0001;
    step(1); expect_val("ovf_clr", 1, 0); check_all();
    tsr_clr = 4'b0000;
    step(1); expect_val("irq_clr", 4, 0); check_all();

    // Down, one-shot, every-cycle ticks, halt after underflow
    en = 1'b0;
    step(1); expect_val("stop_run", 3, 0); check_all();
    dir = 1'b1; one_shot = 1'b1; psc_div = 8'd0; irq_mask = 4'b0010;
    load = 1'b1; load_val = 8'h02;
    step(1);
    load = 1'b0; en = 1'b1;
    step(1); expect_val("dn_start", 0, 8'h02); check_all();
    step(1); expect_val("dn_1", 0, 8'h01); check_all();
    step(1); expect_val("dn_0", 0, 8'h00); check_all();
    step(1);
    expect_val("dn_wrap", 0, 8'h10); expect_val("dn_unf", 1, 4'b0010);
    expect_val("dn_halt", 3, 0); check_all();
    step(3);
    expect_val("halt_hold", 0, 8'h10); expect_val("halt_run", 3, 0);
    expect_val("halt_irq", 4, 1); check_all();
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(1); expect_val("rerun", 3, 1); check_all();
    step(1); expect_val("rerun_cnt", 0, 8'h0F); check_all();
    en = 1'b0; tsr_clr = 4'hF;
    step(1); expect_val("clr_all", 1, 0); check_all();
    tsr_clr = 4'h0;

    // External ticks from clk_in pulses at random offsets
    dir = 1'b0; one_shot = 1'b0; clk_sel = 1'b1; load = 1'b1; load_val = 8'h00;
    step(1);
    load = 1'b0; en = 1'b1;
    step(1);
    for (int p = 0; p < 5; p++) begin
      prev = tcnt;
      #($urandom_range(0, 7));
      clk_in = 1'b1;
      lat = 0;
      for (int e = 1; e <= 4 && lat == 0; e++) begin
        @(posedge PCLK);
        #1;
        if (tcnt != prev) lat = e;
      end
      lat_ok = (lat >= 1) && (lat <= 3);
      expect_val("ext_inc", 0, 32'(8'(p + 1))); expect_val("ext_latency", 5, 1);
      check_all();
      step(2);
      clk_in = 1'b0;
      step(4);
    end
    expect_val("ext_five", 0, 8'h05); check_all();
    clk_in = 1'b1;
    step(12); expect_val("ext_held_high", 0, 8'h06); check_all();

    // Compare match; clear in the setting cycle loses, later clear wins
    clk_sel = 1'b0; psc_div = 8'd0; cmp_val = 8'h05; load = 1'b1; load_val = 8'h03;
    step(1); expect_val("cmp_load", 0, 8'h03); expect_val("cmp_no_load_flag", 1, 0); check_all();
    load = 1'b0;
    step(1); expect_val("cmp_4", 0, 8'h04); check_all();
    tsr_clr = 4'b0100;
    step(1); expect_val("cmp_5", 0, 8'h05); expect_val("cmp_set_wins", 1, 4'b0100); check_all();
    step(1); expect_val("cmp_clr", 1, 0); check_all();
    tsr_clr = 4'b0000; en = 1'b0;
    step(1);

    // Load coincident with a wrap tick
    cmp_val = 8'hAA; load = 1'b1; load_val = 8'hFE;
    step(1);
    load = 1'b0; en = 1'b1;
    step(1);
    step(1); expect_val("pre_wrap", 0, 8'hFF); check_all();
    load = 1'b1; load_val = 8'h33;
    step(1);
    expect_val("load_wins", 0, 8'h33); expect_val("load_no_ovf", 1, 0);
    expect_val("load_run", 3, 1); check_all();
    load = 1'b0;
    step(2);
    #3;
    PRESETn = 1'b0;
    #1;
    expect_val("async_tcnt", 0, 0); expect_val("async_run", 3, 0);
    expect_val("async_tsr", 1, 0); expect_val("async_irq", 4, 0); check_all();
    en = 1'b0; clk_in = 1'b0; irq_mask = 4'b0000;
    step(2);
    PRESETn = 1'b1;

    // Capture (expected zero when the capture unit is not built)
    load = 1'b1; load_val = 8'h42;
    step(1);
    load = 1'b0; cap_in = 1'b1;
    step(4);
    expect_val("cap_val", 2, CAP ? 32'h42 : 32'h0); expect_val("cap_flag", 1, CAP ? 32'h8 : 32'h0);
    expect_val("cap_tcnt", 0, 8'h42); check_all();
    load = 1'b1; load_val = 8'h55;
    step(1);
    load = 1'b0; cap_in = 1'b0;
    step(3);
    cap_in = 1'b1;
    step(2);
    load = 1'b1; load_val = 8'h77;
    step(1);
    load = 1'b0;
    expect_val("cap_preload", 2, CAP ? 32'h55 : 32'h0); expect_val("cap_load_tcnt", 0, 8'h77);
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
